approx_pe_accumulator: RTL and testbench

- Downstream consumer of the approximate multiplication unit inside each processing element.
- Takes the signed approximate product, one per beat, and accumulates a dot-product tile into a wide register. Accumulation may saturate.
- When the tile is complete, presents the result over a valid/ready handshake to the PE output / column drain path.
- Supports back-to-back tiles with no bubble when the downstream consumer is ready.

---
 rtl/apt_pkg.sv | 33 +++
 rtl/sat_adder.sv | 35 +++
 rtl/approx_pe_accumulator.sv | 154 +++++++++++++++
 tb/tb_approx_pe_accumulator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apt_pkg.sv
// Shared definitions for the approximate-PE accumulator: FSM state codes,
// accumulator limit constants and sign extension helpers.
package apt_pkg;

  // Widest accumulator the helper functions can describe.
  localparam int unsigned MAX_BW = 64;
  localparam int unsigned IDX_BW = $clog2(MAX_BW);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  // Largest positive value of a w-bit two's-complement number, sign-extended to MAX_BW.
  function automatic logic [MAX_BW-1:0] acc_max(input int unsigned w);
    return (MAX_BW'(1) << (w - 1)) - MAX_BW'(1);
  endfunction

  // Most negative value of a w-bit two's-complement number, sign-extended to MAX_BW.
  function automatic logic [MAX_BW-1:0] acc_min(input int unsigned w);
    return ~acc_max(w);
  endfunction

  // Treat the low w bits of x as signed and sign-extend them to MAX_BW.
  function automatic logic [MAX_BW-1:0] sext(input logic [MAX_BW-1:0] x,
                                             input int unsigned w);
    logic [MAX_BW-1:0] mask;
    mask = (MAX_BW'(1) << w) - MAX_BW'(1);
    return x[IDX_BW'(w - 1)] ? (x | ~mask) : (x & mask);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed adder with overflow detect and optional clamping.
//   a_i, b_i : signed ACC_BW-bit operands
//   sum_c    : clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//   ovf_c    : the true sum does not fit in ACC_BW bits
module sat_adder
  import apt_pkg::*;
#(
  parameter int unsigned ACC_BW   = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_BW-1:0] a_i,
  input  logic [ACC_BW-1:0] b_i,
  output logic [ACC_BW-1:0] sum_c,
  output logic              ovf_c
);

  localparam int unsigned EXT_BW = ACC_BW + 1;

  localparam logic [ACC_BW-1:0] SAT_MAX = ACC_BW'(acc_max(ACC_BW));
  localparam logic [ACC_BW-1:0] SAT_MIN = ACC_BW'(acc_min(ACC_BW));

  logic [EXT_BW-1:0] wide_sum;

  // One guard bit: overflow exactly when the two top bits disagree.
  always_comb begin
    wide_sum = {a_i[ACC_BW-1], a_i} + {b_i[ACC_BW-1], b_i};
    ovf_c    = wide_sum[ACC_BW] ^ wide_sum[ACC_BW-1];
    sum_c    = wide_sum[ACC_BW-1:0];
    if (SATURATE && ovf_c) begin
      // Guard bit carries the true sign of the sum.
      sum_c = wide_sum[ACC_BW] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/approx_pe_accumulator.sv
// Accumulates signed approximate products into a dot-product tile and hands
// the finished tile downstream over a valid/ready handshake.
//   prod_in/prod_valid/prod_first/prod_last/prod_ready : product beat stream
//   acc_out/acc_beats/acc_ovf/acc_valid/acc_ready      : tile result handshake
//   proto_err                                          : sticky framing error
module approx_pe_accumulator
  import apt_pkg::*;
#(
  parameter int unsigned A_BW     = 8,
  parameter int unsigned B_BW     = 8,
  parameter int unsigned ACC_BW   = 32,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned CNT_BW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [A_BW+B_BW-1:0]   prod_in,
  input  logic                   prod_valid,
  input  logic                   prod_first,
  input  logic                   prod_last,
  output logic                   prod_ready,
  output logic [ACC_BW-1:0]      acc_out,
  output logic [CNT_BW-1:0]      acc_beats,
  output logic                   acc_ovf,
  output logic                   acc_valid,
  input  logic                   acc_ready,
  output logic                   proto_err
);

  localparam int unsigned PROD_BW = A_BW + B_BW;

  state_t              state_q, state_d;
  logic [ACC_BW-1:0]   acc_q, acc_d;
  logic [CNT_BW-1:0]   beats_q, beats_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;

  logic [ACC_BW-1:0]   prod_sext;
  logic [ACC_BW-1:0]   add_sum;
  logic                add_ovf;
  logic                beat_acc;

  // Ready is a function of state and acc_ready only, never of prod_valid.
  always_comb begin
    prod_ready = (state_q != ST_HOLD) | acc_ready;
  end

  always_comb begin
    prod_sext = ACC_BW'(sext(MAX_BW'(prod_in), PROD_BW));
    beat_acc  = prod_valid & prod_ready;
  end

  sat_adder #(
    .ACC_BW   (ACC_BW),
    .SATURATE (SATURATE)
  ) u_sat_adder (
    .a_i   (acc_q),
    .b_i   (prod_sext),
    .sum_c (add_sum),
    .ovf_c (add_ovf)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          if (prod_first) begin
            acc_d   = prod_sext;
            beats_d = CNT_BW'(1);
            ovf_d   = 1'b0;
            state_d = prod_last ? ST_HOLD : ST_ACCUM;
          end else begin
            perr_d  = 1'b1;
          end
        end
      end

      ST_ACCUM: begin
        if (beat_acc) begin
          if (prod_first) begin
            // A stray first restarts the tile from this beat.
            acc_d   = prod_sext;
            beats_d = CNT_BW'(1);
            ovf_d   = 1'b0;
            perr_d  = 1'b1;
          end else begin
            acc_d   = add_sum;
            beats_d = (&beats_q) ? beats_q : beats_q + CNT_BW'(1);
            ovf_d   = ovf_q | add_ovf;
          end
          state_d = prod_last ? ST_HOLD : ST_ACCUM;
        end
      end

      ST_HOLD: begin
        if (acc_ready) begin
          if (beat_acc && prod_first) begin
            // Result drains and the next tile loads in the same cycle.
            acc_d   = prod_sext;
            beats_d = CNT_BW'(1);
            ovf_d   = 1'b0;
            state_d = prod_last ? ST_HOLD : ST_ACCUM;
          end else if (beat_acc) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    acc_out   = acc_q;
    acc_beats = beats_q;
    acc_ovf   = ovf_q;
    acc_valid = valid_q;
    proto_err = perr_q;
  end

endmodule

// File: tb/tb_approx_pe_accumulator.sv
// Bench for approx_pe_accumulator: three instances (32-bit saturating,
// 16-bit saturating, 16-bit wrapping) share one stimulus stream and are each
// compared against a tile-level arithmetic model every cycle.
module tb_approx_pe_accumulator;

  localparam int unsigned NI = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        prod_first;
  logic        prod_last;
  logic        acc_ready;

  logic        prod_ready0, prod_ready1, prod_ready2;
  logic [31:0] acc_out0;
  logic [15:0] acc_out1, acc_out2;
  logic [15:0] acc_beats0, acc_beats1, acc_beats2;
  logic        acc_ovf0, acc_ovf1, acc_ovf2;
  logic        acc_valid0, acc_valid1, acc_valid2;
  logic        proto_err0, proto_err1, proto_err2;

  approx_pe_accumulator #(.ACC_BW(32), .SATURATE(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_first(prod_first), .prod_last(prod_last), .prod_ready(prod_ready0),
    .acc_out(acc_out0), .acc_beats(acc_beats0), .acc_ovf(acc_ovf0),
    .acc_valid(acc_valid0), .acc_ready(acc_ready), .proto_err(proto_err0));

  approx_pe_accumulator #(.ACC_BW(16), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_first(prod_first), .prod_last(prod_last), .prod_ready(prod_ready1),
    .acc_out(acc_out1), .acc_beats(acc_beats1), .acc_ovf(acc_ovf1),
    .acc_valid(acc_valid1), .acc_ready(acc_ready), .proto_err(proto_err1));

  approx_pe_accumulator #(.ACC_BW(16), .SATURATE(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_first(prod_first), .prod_last(prod_last), .prod_ready(prod_ready2),
    .acc_out(acc_out2), .acc_beats(acc_beats2), .acc_ovf(acc_ovf2),
    .acc_valid(acc_valid2), .acc_ready(acc_ready), .proto_err(proto_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered into arrays indexed by instance.
  longint g_acc[NI];
  longint g_beats[NI];
  longint g_ovf[NI];
  longint g_val[NI];
  longint g_perr[NI];
  longint g_rdy[NI];

  always_comb begin
    g_acc[0]   = longint'($signed(acc_out0));
    g_acc[1]   = longint'($signed(acc_out1));
    g_acc[2]   = longint'($signed(acc_out2));
    g_beats[0] = longint'(acc_beats0);
    g_beats[1] = longint'(acc_beats1);
    g_beats[2] = longint'(acc_beats2);
    g_ovf[0]   = longint'(acc_ovf0);
    g_ovf[1]   = longint'(acc_ovf1);
    g_ovf[2]   = longint'(acc_ovf2);
    g_val[0]   = longint'(acc_valid0);
    g_val[1]   = longint'(acc_valid1);
    g_val[2]   = longint'(acc_valid2);
    g_perr[0]  = longint'(proto_err0);
    g_perr[1]  = longint'(proto_err1);
    g_perr[2]  = longint'(proto_err2);
    g_rdy[0]   = longint'(prod_ready0);
    g_rdy[1]   = longint'(prod_ready1);
    g_rdy[2]   = longint'(prod_ready2);
  end

  // Reference model: tile phase (0 idle, 1 summing, 2 result waiting),
  // running sum held as a plain integer, beat count, flags.
  int     m_bw[NI]  = '{32, 16, 16};
  bit     m_sat[NI] = '{1'b1, 1'b1, 1'b0};
  int     m_phase[NI];
  longint m_acc[NI];
  longint m_beats[NI];
  bit     m_ovf[NI];
  bit     m_perr[NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Fit an exact integer sum into w signed bits by clamping or wrapping.
  function automatic longint fit(input longint s, input int w, input bit sat_en,
                                 output bit o);
    longint span, hi, lo, r;
    span = longint'(1) << w;
    hi   = span / 2 - 1;
    lo   = -(span / 2);
    o    = (s > hi) || (s < lo);
    r    = s;
    if (o) begin
      if (sat_en) r = (s > hi) ? hi : lo;
      else begin
        r = (s - lo) % span;
        if (r < 0) r += span;
        r += lo;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_phase[i] = 0; m_acc[i] = 0; m_beats[i] = 0; m_ovf[i] = 0; m_perr[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("%s acc_out[%0d]", tag, i),   g_acc[i],   m_acc[i]);
      check_val($sformatf("%s acc_beats[%0d]", tag, i), g_beats[i], m_beats[i]);
      check_val($sformatf("%s acc_ovf[%0d]", tag, i),   g_ovf[i],   longint'(m_ovf[i]));
      check_val($sformatf("%s acc_valid[%0d]", tag, i), g_val[i],   longint'(m_phase[i] == 2));
      check_val($sformatf("%s proto_err[%0d]", tag, i), g_perr[i],  longint'(m_perr[i]));
    end
  endtask

  // One clock of stimulus: drive, check ready, advance model, clock, check outputs.
  task automatic step(input bit v, input bit f, input bit l, input int d, input bit r,
                      input string tag);
    longint p;
    bit     rdy, acc, o;
    prod_valid = v;
    prod_first = f;
    prod_last  = l;
    prod_in    = 16'(d);
    acc_ready  = r;
    p = longint'($signed(prod_in));
    #1;
    for (int i = 0; i < NI; i++) begin
      rdy = (m_phase[i] != 2) || r;
      check_val($sformatf("%s prod_ready[%0d]", tag, i), g_rdy[i], longint'(rdy));
      acc = v && rdy;
      if (acc && f && (m_phase[i] != 2 || r)) begin
        if (m_phase[i] == 1) m_perr[i] = 1'b1;
        m_acc[i] = p; m_beats[i] = 1; m_ovf[i] = 1'b0;
        m_phase[i] = l ? 2 : 1;
      end else if (acc && m_phase[i] == 1) begin
        m_acc[i] = fit(m_acc[i] + p, m_bw[i], m_sat[i], o);
        m_ovf[i] = m_ovf[i] | o;
        if (m_beats[i] < 65535) m_beats[i]++;
        m_phase[i] = l ? 2 : 1;
      end else if (acc) begin
        m_perr[i] = 1'b1;
        m_phase[i] = 0;
      end else if (m_phase[i] == 2 && r) begin
        m_phase[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    prod_valid = 1'b0;
    prod_first = 1'b0;
    prod_last  = 1'b0;
    acc_ready  = 1'b0;
    rst_n      = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    prod_first = 1'b0;
    prod_last  = 1'b0;
    acc_ready  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Three-beat tile: 3 - 5 + 10.
    step(1, 1, 0, 3,  1, "dot0");
    step(1, 0, 0, -5, 1, "dot1");
    step(1, 0, 1, 10, 1, "dot2");
    check_val("dot sum", g_acc[0], 8);
    check_val("dot beats", g_beats[0], 3);
    check_val("dot valid", g_val[0], 1);
    step(0, 0, 0, 0, 1, "dot_drain");
    check_val("dot valid pulse", g_val[0], 0);

    // Four beats of 0x3F01 overflow the 16-bit instances.
    step(1, 1, 0, 16129, 1, "ovf0");
    step(1, 0, 0, 16129, 1, "ovf1");
    step(1, 0, 0, 16129, 1, "ovf2");
    step(1, 0, 1, 16129, 1, "ovf3");
    check_val("sat16 sum", g_acc[1], 32767);
    check_val("sat16 ovf", g_ovf[1], 1);
    check_val("wrap16 sum", g_acc[2], -1020);
    check_val("wrap16 ovf", g_ovf[2], 1);
    check_val("acc32 sum", g_acc[0], 64516);
    step(0, 0, 0, 0, 1, "ovf_drain");

    // Result held under backpressure, then a first beat loads in the drain cycle.
    step(1, 1, 1, -7, 0, "hold0");
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 1, 55, 0, "hold_bp");
      check_val("hold value", g_acc[0], -7);
      check_val("hold ready", g_rdy[0], 0);
    end
    step(1, 1, 1, 2, 1, "hold_swap");
    check_val("swap sum", g_acc[0], 2);
    check_val("swap valid", g_val[0], 1);
    step(0, 0, 0, 0, 1, "swap_drain");

    // Framing errors: orphan beat in idle, then a restart inside a tile.
    step(1, 0, 0, 5, 1, "orphan");
    check_val("orphan perr", g_perr[0], 1);
    step(1, 1, 0, 7, 1, "restart0");
    step(1, 1, 0, 1, 1, "restart1");
    step(1, 0, 1, 2, 1, "restart2");
    check_val("restart sum", g_acc[0], 3);
    check_val("restart beats", g_beats[0], 2);
    check_val("perr sticky", g_perr[0], 1);
    step(0, 0, 0, 0, 1, "restart_drain");

    // Reset in the middle of a tile discards it.
    step(1, 1, 0, 9, 1, "abort0");
    step(1, 0, 0, 9, 1, "abort1");
    do_reset();
    step(1, 1, 0, 4, 1, "post0");
    step(1, 0, 1, 4, 1, "post1");
    check_val("post sum", g_acc[0], 8);
    check_val("post beats", g_beats[0], 2);
    step(0, 0, 0, 0, 1, "post_drain");

    // Randomized traffic with random backpressure and occasional bad framing.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), int'($signed(16'($urandom))),
           ($urandom_range(0, 2) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
